// File: rtl/stopwatch_bcd_core_if.sv
// Control and display bundle for stopwatch_bcd_core.
// The core takes the slave side; whatever sources the debounced buttons takes master.
interface stopwatch_bcd_core_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       running;
  logic       held;
  logic       overflow;

  modport master (
    output start_stop,
    output clear,
    output lap,
    input  digit3,
    input  digit2,
    input  digit1,
    input  digit0,
    input  running,
    input  held,
    input  overflow
  );

  modport slave (
    input  start_stop,
    input  clear,
    input  lap,
    output digit3,
    output digit2,
    output digit1,
    output digit0,
    output running,
    output held,
    output overflow
  );
endinterface

// File: rtl/stopwatch_bcd_core.sv
// Four-digit BCD stopwatch (SS.hh) with start/stop, clear and optional lap hold.
// Lap hold is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_core #(
  parameter int unsigned TICKS_PER_HUNDREDTH = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  stopwatch_bcd_core_if.slave bus
);

  localparam int unsigned PrescW =
      (TICKS_PER_HUNDREDTH > 2) ? $clog2(TICKS_PER_HUNDREDTH) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICKS_PER_HUNDREDTH - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRunning = 2'd1;
  localparam logic [1:0] StPaused  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [3:0][3:0]   cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic              ss_prev_q, clr_prev_q;
  logic              ss_ev, clr_ev;
  logic              is_running, tick, wrap;
  logic [3:0][3:0]   shown;
  logic              held_out;

  // Edge detect: prev registers come out of reset high so a button held
  // through reset release does not look like a press.
  assign ss_ev  = bus.start_stop & ~ss_prev_q;
  assign clr_ev = bus.clear & ~clr_prev_q;

  assign is_running = (state_q == StRunning);
  assign tick       = is_running && (presc_q == PrescMax);

  always_comb begin
    state_d = state_q;
    if (clr_ev) begin
      state_d = StIdle;
    end else if (ss_ev) begin
      case (state_q)
        StIdle:    state_d = StRunning;
        StRunning: state_d = StPaused;
        StPaused:  state_d = StRunning;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (clr_ev) begin
      presc_d = '0;
    end else if (is_running) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  // Ripple BCD increment; digits at or above 9 roll to 0 so a corrupted
  // digit cannot stick outside the BCD range.
  always_comb begin
    logic carry;
    cnt_d = cnt_q;
    carry = tick;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_q[i] >= 4'd9) begin
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    wrap = carry;
    if (clr_ev) begin
      cnt_d = '0;
    end
  end

  assign overflow_d = wrap & ~clr_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      ss_prev_q  <= 1'b1;
      clr_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      ss_prev_q  <= bus.start_stop;
      clr_prev_q <= bus.clear;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic            lap_prev_q;
  logic            lap_ev;
  logic            held_q, held_d;
  logic [3:0][3:0] disp_q, disp_d;

  assign lap_ev = bus.lap & ~lap_prev_q;

  always_comb begin
    held_d = held_q;
    disp_d = disp_q;
    if (clr_ev) begin
      held_d = 1'b0;
    end else if (lap_ev && (state_q != StIdle)) begin
      held_d = ~held_q;
    end
    // Freeze the live count on the rising edge of the hold.
    if (held_d && !held_q) begin
      disp_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_prev_q <= 1'b1;
      held_q     <= 1'b0;
      disp_q     <= '0;
    end else begin
      lap_prev_q <= bus.lap;
      held_q     <= held_d;
      disp_q     <= disp_d;
    end
  end

  assign shown    = held_q ? disp_q : cnt_q;
  assign held_out = held_q;
`else
  logic unused_lap;
  assign unused_lap = bus.lap;
  assign shown      = cnt_q;
  assign held_out   = 1'b0;
`endif

  assign bus.digit3   = shown[3];
  assign bus.digit2   = shown[2];
  assign bus.digit1   = shown[1];
  assign bus.digit0   = shown[0];
  assign bus.running  = is_running;
  assign bus.held     = held_out;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Directed bench for stopwatch_bcd_core at TICKS_PER_HUNDREDTH = 4.
// Lap-hold scenarios follow STOPWATCH_LAP_EN the same way the core does.
module tb_stopwatch_bcd_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] shown;
  int          n_cmp = 0;
  int          n_bad = 0;

  stopwatch_bcd_core_if sw_if ();

  stopwatch_bcd_core #(
    .TICKS_PER_HUNDREDTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sw_if.slave)
  );

  always #5 clk = ~clk;

  assign shown = {sw_if.digit3, sw_if.digit2, sw_if.digit1, sw_if.digit0};

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_ss();
    sw_if.start_stop = 1'b1;
    cycles(1);
    sw_if.start_stop = 1'b0;
  endtask

  task automatic press_lap();
    sw_if.lap = 1'b1;
    cycles(1);
    sw_if.lap = 1'b0;
  endtask

  task automatic do_reset();
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.lap        = 1'b0;
    reset            = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_reset();
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.lap        = 1'b0;
    reset            = 1'b1;
    #2;
    n_cmp++;
    if (shown !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_digits: got %h want %h", shown, 16'h0000);
    end
    n_cmp++;
    if ({sw_if.running, sw_if.held, sw_if.overflow} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want %b",
               {sw_if.running, sw_if.held, sw_if.overflow}, 3'b000);
    end
    cycles(2);
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    press_ss();
    cycles(4 * 1234);
    n_cmp++;
    if (shown !== 16'h1234) begin
      n_bad++;
      $display("FAIL mid_run_count: got %h want %h", shown, 16'h1234);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (shown !== 16'h0000) begin
      n_bad++;
      $display("FAIL async_reset_digits: got %h want %h", shown, 16'h0000);
    end
    n_cmp++;
    if (sw_if.running !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_running: got %b want %b", sw_if.running, 1'b0);
    end
    cycles(1);
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_count_carry();
    do_reset();
    press_ss();
    n_cmp++;
    if (sw_if.running !== 1'b1) begin
      n_bad++;
      $display("FAIL start_running: got %b want %b", sw_if.running, 1'b1);
    end
    cycles(4 * 57 - 1);
    n_cmp++;
    if (shown !== 16'h0056) begin
      n_bad++;
      $display("FAIL pre_tick_hold: got %h want %h", shown, 16'h0056);
    end
    cycles(1);
    n_cmp++;
    if (shown !== 16'h0057) begin
      n_bad++;
      $display("FAIL count_57: got %h want %h", shown, 16'h0057);
    end
    cycles(4 * 43);
    n_cmp++;
    if (shown !== 16'h0100) begin
      n_bad++;
      $display("FAIL carry_0100: got %h want %h", shown, 16'h0100);
    end
  endtask

  // Continues from 01.00 left by test_count_carry.
  task automatic test_overflow();
    cycles(4 * 9899);
    n_cmp++;
    if (shown !== 16'h9999) begin
      n_bad++;
      $display("FAIL reach_9999: got %h want %h", shown, 16'h9999);
    end
    cycles(3);
    n_cmp++;
    if ({shown, sw_if.overflow} !== {16'h9999, 1'b0}) begin
      n_bad++;
      $display("FAIL pre_wrap: got %h/%b want %h/%b", shown, sw_if.overflow, 16'h9999, 1'b0);
    end
    cycles(1);
    n_cmp++;
    if ({shown, sw_if.overflow, sw_if.running} !== {16'h0000, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL wrap: got %h/ovf %b/run %b want 0000/1/1",
               shown, sw_if.overflow, sw_if.running);
    end
    cycles(1);
    n_cmp++;
    if ({shown, sw_if.overflow} !== {16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL ovf_one_cycle: got %h/%b want %h/%b", shown, sw_if.overflow, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    press_ss();
    cycles(4 * 5);
    cycles(1);
    press_ss();  // prescaler steps 1 -> 2 on this edge, then holds
    n_cmp++;
    if ({shown, sw_if.running} !== {16'h0005, 1'b0}) begin
      n_bad++;
      $display("FAIL pause_entry: got %h/%b want %h/%b", shown, sw_if.running, 16'h0005, 1'b0);
    end
    cycles(100);
    n_cmp++;
    if (shown !== 16'h0005) begin
      n_bad++;
      $display("FAIL paused_hold: got %h want %h", shown, 16'h0005);
    end
    press_ss();
    cycles(1);
    n_cmp++;
    if ({shown, sw_if.running} !== {16'h0005, 1'b1}) begin
      n_bad++;
      $display("FAIL resume_1: got %h/%b want %h/%b", shown, sw_if.running, 16'h0005, 1'b1);
    end
    cycles(1);
    n_cmp++;
    if (shown !== 16'h0006) begin
      n_bad++;
      $display("FAIL resume_2: got %h want %h", shown, 16'h0006);
    end
  endtask

  task automatic test_lap();
    do_reset();
    press_lap();
    n_cmp++;
    if (sw_if.held !== 1'b0) begin
      n_bad++;
      $display("FAIL lap_idle_ignored: got %b want %b", sw_if.held, 1'b0);
    end
    press_ss();
    cycles(4 * 10);
    press_lap();
    cycles(4 * 20 - 1);
`ifdef STOPWATCH_LAP_EN
    n_cmp++;
    if ({shown, sw_if.held} !== {16'h0010, 1'b1}) begin
      n_bad++;
      $display("FAIL lap_frozen: got %h/%b want %h/%b", shown, sw_if.held, 16'h0010, 1'b1);
    end
    press_lap();
    n_cmp++;
    if ({shown, sw_if.held} !== {16'h0030, 1'b0}) begin
      n_bad++;
      $display("FAIL lap_release: got %h/%b want %h/%b", shown, sw_if.held, 16'h0030, 1'b0);
    end
    press_lap();
    sw_if.lap   = 1'b1;
    sw_if.clear = 1'b1;
    cycles(1);
    sw_if.lap   = 1'b0;
    sw_if.clear = 1'b0;
    n_cmp++;
    if ({shown, sw_if.held} !== {16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL lap_clear_same: got %h/%b want %h/%b", shown, sw_if.held, 16'h0000, 1'b0);
    end
`else
    n_cmp++;
    if ({shown, sw_if.held} !== {16'h0030, 1'b0}) begin
      n_bad++;
      $display("FAIL lap_disabled: got %h/%b want %h/%b", shown, sw_if.held, 16'h0030, 1'b0);
    end
`endif
  endtask

  task automatic test_edge_cases();
    sw_if.start_stop = 1'b1;
    reset            = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(3);
    n_cmp++;
    if ({shown, sw_if.running} !== {16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL held_through_reset: got %h/%b want %h/%b",
               shown, sw_if.running, 16'h0000, 1'b0);
    end
    sw_if.start_stop = 1'b0;
    cycles(1);
    press_ss();
    cycles(4 * 5);
    n_cmp++;
    if (shown !== 16'h0005) begin
      n_bad++;
      $display("FAIL pre_clear_count: got %h want %h", shown, 16'h0005);
    end
    sw_if.start_stop = 1'b1;
    sw_if.clear      = 1'b1;
    cycles(1);
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    n_cmp++;
    if ({shown, sw_if.running} !== {16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL clear_beats_ss: got %h/%b want %h/%b", shown, sw_if.running, 16'h0000, 1'b0);
    end
    cycles(8);
    press_ss();
    cycles(4);
    n_cmp++;
    if ({shown, sw_if.running} !== {16'h0001, 1'b1}) begin
      n_bad++;
      $display("FAIL restart_from_idle: got %h/%b want %h/%b",
               shown, sw_if.running, 16'h0001, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_count_carry();
    test_overflow();
    test_pause_resume();
    test_lap();
    test_edge_cases();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
